// File: rtl/network_pkt_encoder_fsm.sv
// network_pkt_encoder_fsm
//   Transmit-side packet builder for the 4-port router. It accepts one host
//   request, looks up the destination IP for the requested port, and forms
//   the additive CRC (dest_ip + payload) in four chunk cycles with a rippled
//   carry. It then launches {dest_ip, payload, crc} as a one-cycle pulse
//   once the router reports no congestion.
//
// Handshake: a request is taken on a rising edge where req_vld & req_rdy.
//   req_rdy is high only in IDLE. req_vld in any other state is ignored, and
//   nothing is queued.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   req_vld / req_rdy          request handshake
//   req_port_idx               0..3 selects port_1_ip..port_4_ip
//   req_payload                payload carried in the packet
//   req_corrupt                flip crc[0] of this packet
//   port_1_ip..port_4_ip       port IP table
//   congestion                 router FIFO full; holds the launch
//   port_wan_vld, tx_done      one-cycle launch pulse (coincident)
//   port_wan                   last launched packet (held between launches)
//   busy                       block is working on a request
//   state_dbg                  current FSM state encoding
module network_pkt_encoder_fsm #(
    parameter int DEST_IP_LEN = 32,
    parameter int PAYLOAD_LEN = 32,
    parameter int CRC_LEN     = DEST_IP_LEN + 1,
    parameter int PKT_LEN     = DEST_IP_LEN + PAYLOAD_LEN + CRC_LEN,
    parameter int CHUNK_W     = DEST_IP_LEN / 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_vld,
    output logic                   req_rdy,
    input  logic [1:0]             req_port_idx,
    input  logic [PAYLOAD_LEN-1:0] req_payload,
    input  logic                   req_corrupt,
    input  logic [DEST_IP_LEN-1:0] port_1_ip,
    input  logic [DEST_IP_LEN-1:0] port_2_ip,
    input  logic [DEST_IP_LEN-1:0] port_3_ip,
    input  logic [DEST_IP_LEN-1:0] port_4_ip,
    input  logic                   congestion,
    output logic                   port_wan_vld,
    output logic [PKT_LEN-1:0]     port_wan,
    output logic                   tx_done,
    output logic                   busy,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CRC_1 = 3'd2,
        CRC_2 = 3'd3,
        CRC_3 = 3'd4,
        CRC_4 = 3'd5,
        HOLD  = 3'd6
    } state_t;

    state_t state, state_nxt;

    logic [PAYLOAD_LEN-1:0] payload_r;
    logic [1:0]             idx_r;
    logic                   corrupt_r;
    logic [DEST_IP_LEN-1:0] dest_ip_r;
    logic [CRC_LEN-1:0]     crc_r;
    logic                   carry_r;

    logic                   launch;
    logic [CHUNK_W-1:0]     ip_chunk;
    logic [CHUNK_W-1:0]     pl_chunk;
    logic [CHUNK_W:0]       chunk_sum;

    assign req_rdy   = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Next state, launch decision and the chunk operands for this cycle.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        ip_chunk  = '0;
        pl_chunk  = '0;
        case (state)
            IDLE:  if (req_vld) state_nxt = LOAD;
            LOAD:  state_nxt = CRC_1;
            CRC_1: begin
                ip_chunk  = dest_ip_r[0*CHUNK_W +: CHUNK_W];
                pl_chunk  = payload_r[0*CHUNK_W +: CHUNK_W];
                state_nxt = CRC_2;
            end
            CRC_2: begin
                ip_chunk  = dest_ip_r[1*CHUNK_W +: CHUNK_W];
                pl_chunk  = payload_r[1*CHUNK_W +: CHUNK_W];
                state_nxt = CRC_3;
            end
            CRC_3: begin
                ip_chunk  = dest_ip_r[2*CHUNK_W +: CHUNK_W];
                pl_chunk  = payload_r[2*CHUNK_W +: CHUNK_W];
                state_nxt = CRC_4;
            end
            CRC_4: begin
                ip_chunk  = dest_ip_r[3*CHUNK_W +: CHUNK_W];
                pl_chunk  = payload_r[3*CHUNK_W +: CHUNK_W];
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!congestion) begin
                    launch    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;  // unused encoding
        endcase
    end

    // One chunk adder, CHUNK_W+1 wide. The carry moves between chunks only
    // through carry_r.
    assign chunk_sum = {1'b0, ip_chunk} + {1'b0, pl_chunk} + {{CHUNK_W{1'b0}}, carry_r};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            payload_r    <= '0;
            idx_r        <= '0;
            corrupt_r    <= 1'b0;
            dest_ip_r    <= '0;
            crc_r        <= '0;
            carry_r      <= 1'b0;
            port_wan_vld <= 1'b0;
            tx_done      <= 1'b0;
            port_wan     <= '0;
        end else begin
            state        <= state_nxt;
            port_wan_vld <= launch;
            tx_done      <= launch;
            if (launch) port_wan <= {dest_ip_r, payload_r, crc_r};

            case (state)
                IDLE: begin
                    if (req_vld) begin
                        payload_r <= req_payload;
                        idx_r     <= req_port_idx;
                        corrupt_r <= req_corrupt;
                    end
                end
                LOAD: begin
                    // Table is sampled here, so edits after LOAD do not
                    // reach the packet in flight.
                    case (idx_r)
                        2'd0:    dest_ip_r <= port_1_ip;
                        2'd1:    dest_ip_r <= port_2_ip;
                        2'd2:    dest_ip_r <= port_3_ip;
                        default: dest_ip_r <= port_4_ip;
                    endcase
                    carry_r <= 1'b0;
                end
                CRC_1: begin
                    crc_r[0*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    carry_r <= chunk_sum[CHUNK_W];
                end
                CRC_2: begin
                    crc_r[1*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    carry_r <= chunk_sum[CHUNK_W];
                end
                CRC_3: begin
                    crc_r[2*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    carry_r <= chunk_sum[CHUNK_W];
                end
                CRC_4: begin
                    crc_r[3*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    carry_r              <= chunk_sum[CHUNK_W];
                    crc_r[CRC_LEN-1]     <= chunk_sum[CHUNK_W];
                    // crc[0] was settled in CRC_1, so the optional flip is
                    // applied on the edge that enters HOLD.
                    if (corrupt_r) crc_r[0] <= ~crc_r[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_network_pkt_encoder_fsm.sv
// Bench for network_pkt_encoder_fsm: directed literal cases plus a random
// run, all checked each cycle against a cycle-count reference model.
module tb_network_pkt_encoder_fsm;

    localparam int IPW = 32;
    localparam int PLW = 32;
    localparam int CRW = IPW + 1;
    localparam int W   = IPW + PLW + CRW;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           req_vld = 1'b0;
    logic           req_rdy;
    logic [1:0]     req_port_idx = '0;
    logic [PLW-1:0] req_payload = '0;
    logic           req_corrupt = 1'b0;
    logic [IPW-1:0] ip_tab [4];
    logic           congestion = 1'b0;
    logic           port_wan_vld;
    logic [W-1:0]   port_wan;
    logic           tx_done;
    logic           busy;
    logic [2:0]     state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    network_pkt_encoder_fsm dut (
        .clk(clk), .rstn(rstn),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_port_idx(req_port_idx), .req_payload(req_payload),
        .req_corrupt(req_corrupt),
        .port_1_ip(ip_tab[0]), .port_2_ip(ip_tab[1]),
        .port_3_ip(ip_tab[2]), .port_4_ip(ip_tab[3]),
        .congestion(congestion),
        .port_wan_vld(port_wan_vld), .port_wan(port_wan),
        .tx_done(tx_done), .busy(busy), .state_dbg(state_dbg)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A request occupies the block for a fixed six-cycle walk (phase 1..6),
    // then launches from phase 6 on the first uncongested cycle.
    function automatic logic [W-1:0] make_pkt(input logic [IPW-1:0] ip,
                                               input logic [PLW-1:0] pl,
                                               input logic cor);
        logic [CRW-1:0] crc;
        crc = {1'b0, ip} + {1'b0, pl};
        crc[0] = crc[0] ^ cor;
        return {ip, pl, crc};
    endfunction

    int             m_phase = 0;
    logic [PLW-1:0] m_pl = '0;
    logic [1:0]     m_idx = '0;
    logic           m_cor = 1'b0;
    logic [W-1:0]   m_pkt = '0;
    logic           exp_vld = 1'b0;
    logic [W-1:0]   exp_wan = '0;
    logic [W-1:0]   exp_q [$];

    always @(posedge clk) begin
        if (!rstn) begin
            m_phase <= 0;
            exp_vld <= 1'b0;
            exp_wan <= '0;
            exp_q.delete();
        end else begin
            exp_vld <= 1'b0;
            case (m_phase)
                0: if (req_vld) begin
                    m_pl    <= req_payload;
                    m_idx   <= req_port_idx;
                    m_cor   <= req_corrupt;
                    m_phase <= 1;
                end
                1: begin
                    m_pkt   <= make_pkt(ip_tab[m_idx], m_pl, m_cor);
                    exp_q.push_back(make_pkt(ip_tab[m_idx], m_pl, m_cor));
                    m_phase <= 2;
                end
                6: if (!congestion) begin
                    exp_vld <= 1'b1;
                    exp_wan <= m_pkt;
                    m_phase <= 0;
                end
                default: m_phase <= m_phase + 1;
            endcase
        end
    end

    // ---------------- per-cycle scoreboard ----------------
    logic [W-1:0] front;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vld", port_wan_vld, exp_vld);
            chk("tx_done", tx_done, exp_vld);
            chk("req_rdy", req_rdy, m_phase == 0);
            chk("busy", busy, m_phase != 0);
            chk("port_wan", port_wan, exp_wan);
            if (exp_vld) begin
                if (exp_q.size() == 0) begin
                    chk("queue_nonempty", 0, 1);
                end else begin
                    front = exp_q.pop_front();
                    chk("pkt_order", port_wan, front);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_idle();
        int n = 0;
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", req_rdy, 1);
    endtask

    // One request; measures edges from the handshake edge to the launch
    // cycle (inclusive) and holds congestion for cong_len HOLD cycles.
    task automatic send_pkt(input logic [1:0] idx, input logic [PLW-1:0] pl,
                            input logic cor, input logic [IPW-1:0] ip,
                            input int cong_len, input logic [W-1:0] exp_pkt,
                            input int exp_edges);
        int n;
        logic seen;
        wait_idle();
        @(negedge clk);
        ip_tab[idx]  = ip;
        req_port_idx = idx;
        req_payload  = pl;
        req_corrupt  = cor;
        req_vld      = 1'b1;
        congestion   = (cong_len > 0);
        @(posedge clk);
        n = 1;
        seen = 1'b0;
        @(negedge clk);
        req_vld = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (port_wan_vld) seen = 1'b1;
            else congestion = (cong_len > 0) && (n < 6 + cong_len);
        end
        congestion = 1'b0;
        chk("launch_seen", seen, 1);
        chk("latency", n, exp_edges);
        chk("pkt_literal", port_wan, exp_pkt);
        chk("tx_done_lit", tx_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ip_tab[i] = '0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_rdy", req_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wan", port_wan, 0);
        rstn = 1'b1;

        // Basic packet, no congestion.
        send_pkt(2'd0, 32'h12345678, 1'b0, 32'h0A000001, 0,
                 {32'h0A000001, 32'h12345678, 33'h0_1C345679}, 7);
        // Carry ripples through all chunks into the MSB.
        send_pkt(2'd3, 32'h00000001, 1'b0, 32'hFFFFFFFF, 0,
                 {32'hFFFFFFFF, 32'h00000001, 33'h1_00000000}, 7);
        // Five congested HOLD cycles delay the launch by five.
        send_pkt(2'd0, 32'h12345678, 1'b0, 32'h0A000001, 5,
                 {32'h0A000001, 32'h12345678, 33'h0_1C345679}, 12);
        // Corrupted CRC bit 0.
        send_pkt(2'd1, 32'h00000001, 1'b1, 32'h00000002, 0,
                 {32'h00000002, 32'h00000001, 33'h0_00000002}, 7);

        // req_vld held high with alternating payloads.
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            req_vld      = 1'b1;
            req_port_idx = 2'($urandom_range(3));
            req_payload  = (i % 2 == 1) ? 32'hAAAA5555 : 32'h5555AAAA;
            req_corrupt  = 1'b0;
        end
        @(negedge clk);
        req_vld = 1'b0;
        wait_idle();

        // Reset during CRC_2 discards the packet.
        @(negedge clk);
        req_port_idx = 2'd2;
        req_payload  = 32'hDEADBEEF;
        req_vld      = 1'b1;
        @(posedge clk);         // handshake edge
        @(negedge clk);
        req_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);         // now in CRC_2
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rdy", req_rdy, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_wan", port_wan, 0);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        send_pkt(2'd2, 32'h00010002, 1'b0, 32'h7FFF8000, 0,
                 {32'h7FFF8000, 32'h00010002, 33'h0_80008002}, 7);

        // Random traffic with table edits, congestion and rare resets.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            req_vld      = ($urandom_range(1) == 1);
            req_port_idx = 2'($urandom_range(3));
            req_payload  = $urandom;
            req_corrupt  = ($urandom_range(3) == 0);
            congestion   = ($urandom_range(9) < 3);
            if ($urandom_range(3) == 0) ip_tab[$urandom_range(3)] = $urandom;
            rstn         = ($urandom_range(149) != 0);
        end
        @(negedge clk);
        rstn       = 1'b1;
        req_vld    = 1'b0;
        congestion = 1'b0;
        repeat (12) @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/network_pkt_encoder_fsm.md
Name: network_pkt_encoder_fsm

Overview:
Transmit-side packet builder that generates WAN packets for the 4-port router: {Destination_IP, Payload, CRC}. It takes a host request (payload plus target port index) and looks up the destination IP from a 4-entry port IP table. It computes the additive CRC over 4 chunk cycles with ripple carry, then launches the packet as a single-cycle port_wan_vld pulse. The launch is throttled by the router's congestion flag. Optional CRC corruption supports error-path testing of the receiver.

Parameters:
DEST_IP_LEN, 32, destination IP width; must equal PAYLOAD_LEN and be divisible by 4
PAYLOAD_LEN, 32, payload width
CRC_LEN, DEST_IP_LEN+1, CRC width: full-width sum plus carry-out MSB
PKT_LEN, DEST_IP_LEN+PAYLOAD_LEN+CRC_LEN, packet width
CHUNK_W, DEST_IP_LEN/4, adder chunk width per CRC cycle

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_vld  in  1  host request valid
req_rdy  out  1  block can accept a request
req_port_idx  in  2  target port: 0..3 selects port_1..port_4
req_payload  in  PAYLOAD_LEN  payload
req_corrupt  in  1  invert CRC bit 0 of this packet
port_1_ip..port_4_ip  in  DEST_IP_LEN each  port IP table
congestion  in  1  router FIFO full; blocks launch
port_wan_vld  out  1  one-cycle packet valid pulse
port_wan  out  PKT_LEN  packet: dest_ip at MSBs, payload, CRC at LSBs
tx_done  out  1  pulse coincident with port_wan_vld
busy  out  1  state != IDLE

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. On reset: state=IDLE; port_wan_vld=0, tx_done=0, port_wan=0, busy=0, req_rdy=1. All internal registers (payload, idx, corrupt, dest_ip, sum, carry) are cleared.
- States: IDLE, LOAD, CRC_1, CRC_2, CRC_3, CRC_4, HOLD.
- req_rdy = (state==IDLE), combinational. Handshake = req_vld & req_rdy at a rising edge.
- IDLE: on handshake, register payload, idx and corrupt; go to LOAD. With no handshake, stay in IDLE. req_vld while not IDLE is ignored; no queueing.
- LOAD: register dest_ip = port_(idx+1)_ip as sampled in this cycle. Clear the carry register. Go to CRC_1.
- CRC_k (k=1..4): sum chunk k-1 = dest_ip[(k-1)*CHUNK_W +: CHUNK_W] + payload[same slice] + carry_reg. Store the chunk result into crc[(k-1)*CHUNK_W +: CHUNK_W] and the carry-out into carry_reg. Advance to CRC_(k+1); CRC_4 goes to HOLD. The CRC_4 carry-out becomes crc[CRC_LEN-1].
- Final CRC equals (dest_ip + payload) at full CRC_LEN width. If corrupt is set, crc[0] is inverted when HOLD is entered.
- HOLD: while congestion=1, stay in HOLD with no output activity. When congestion=0 is sampled in HOLD, at the next edge:
  - port_wan <= {dest_ip, payload, crc}
  - port_wan_vld <= 1 and tx_done <= 1 for exactly one cycle
  - state <= IDLE
- Latency: handshake at edge E0 leads to port_wan_vld high in the cycle after E6 when there is no congestion. Minimum request-to-request spacing is 7 cycles. req_rdy is high in the same cycle as port_wan_vld, so a new handshake can occur at E7.
- port_wan holds its last launched packet until the next launch. It never changes outside a launch edge.
- congestion is sampled only in HOLD. Congestion rising while in LOAD/CRC_k has no effect until HOLD.
- Port table changes after LOAD do not affect the packet in flight. Changes between handshake and LOAD do take effect.
- Reset mid-operation in any state: the packet is discarded, no vld pulse is issued, and reset values apply on the next cycle.
- Illegal state encodings recover to IDLE.
- All arithmetic is unsigned. Chunk adders are CHUNK_W+1 bits wide. The carry chains across chunks only through carry_reg.

Test Plan:
- idx=0, port_1_ip=0x0A000001, payload=0x12345678, no congestion -> port_wan_vld pulse 7 edges after handshake (in the cycle after E6). port_wan = {0x0A000001, 0x12345678, 33'h0_1C345679}. tx_done coincident.
- idx=3, port_4_ip=0xFFFFFFFF, payload=0x00000001 -> CRC=33'h1_00000000. The carry ripples through all 4 chunks and the MSB carry is set.
- Same as case 1, but congestion=1 for 5 cycles after HOLD entry -> vld delayed exactly 5 cycles; port_wan unchanged until launch; req_rdy low throughout.
- req_corrupt=1, ip=0x00000002, payload=0x00000001 -> CRC=33'h0_00000002 (bit 0 flipped from 0x3).
- req_vld held high continuously with alternating payloads -> requests accepted only at IDLE edges, one packet every 7 cycles, no duplicates or drops.
- rstn pulsed low during CRC_2 -> no vld pulse; all outputs return to reset values; the next request produces a correct packet.
